ibex_multdiv_issue: RTL and testbench

- Initiator-side sequencer for the fast multiply/divide unit.
- Accepts one M-extension request at a time from the ID/decoder over a valid/ready handshake.
- Registers the operands and drives the unit's enables, operator and operands until the unit signals valid, then holds the result for writeback.
- Handles kill of in-flight operations by draining the unit so it returns to its idle state.
- Contains an optional single-entry result cache for back-to-back identical requests.

---
 rtl/ibex_multdiv_issue.sv | 189 ++++++++++++++++++
 tb/tb_ibex_multdiv_issue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_issue.sv
// Issue sequencer between the ID/decoder and the fast multiply/divide unit.
// Latency: result valid one cycle after md_valid_i, or one cycle after accept on a cache hit.
// Backpressure: one op in flight; req_ready_o low until the held result is consumed by writeback.

package ibex_pkg;
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;
endpackage

module ibex_multdiv_issue
  import ibex_pkg::*;
#(
  parameter bit ResultCache = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  md_op_e      req_op_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic [4:0]  req_rd_addr_i,
  input  logic        kill_i,

  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output md_op_e      md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  output logic        md_ready_id_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,

  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] wb_result_o,
  output logic [4:0]  wb_rd_addr_o,

  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    DRAIN  = 2'b10,
    RESULT = 2'b11
  } state_e;

  state_e state_q, state_d;

  md_op_e      op_q;
  logic [1:0]  mode_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;

  logic        cache_vld_q;
  md_op_e      cache_op_q;
  logic [1:0]  cache_mode_q;
  logic [31:0] cache_a_q;
  logic [31:0] cache_b_q;
  logic [31:0] cache_res_q;

  logic accept;
  logic hit;
  logic unit_active;
  logic cache_upd;
  logic result_upd;

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign req_ready_o = ~rst_i & ~kill_i &
                       ((state_q == IDLE) | ((state_q == RESULT) & wb_ready_i));
  assign accept      = req_valid_i & req_ready_o;

  assign hit = ResultCache & cache_vld_q &
               (req_op_i == cache_op_q) &
               (req_signed_mode_i == cache_mode_q) &
               (req_op_a_i == cache_a_q) &
               (req_op_b_i == cache_b_q);

  assign unit_active = (state_q == BUSY) | (state_q == DRAIN);
  // A result that arrives while draining is still a correct function of its tag.
  assign cache_upd   = unit_active & md_valid_i;
  assign result_upd  = (state_q == BUSY) & md_valid_i & ~kill_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = hit ? RESULT : BUSY;
        end
      end
      BUSY: begin
        if (kill_i) begin
          state_d = md_valid_i ? IDLE : DRAIN;
        end else if (md_valid_i) begin
          state_d = RESULT;
        end
      end
      DRAIN: begin
        if (md_valid_i) begin
          state_d = IDLE;
        end
      end
      RESULT: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (accept) begin
          state_d = hit ? RESULT : BUSY;
        end else if (wb_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q         <= MD_OP_MULL;
      mode_q       <= 2'b00;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      rd_q         <= 5'h0;
      result_q     <= 32'h0;
      cache_vld_q  <= 1'b0;
      cache_op_q   <= MD_OP_MULL;
      cache_mode_q <= 2'b00;
      cache_a_q    <= 32'h0;
      cache_b_q    <= 32'h0;
      cache_res_q  <= 32'h0;
    end else begin
      if (accept) begin
        op_q   <= req_op_i;
        mode_q <= req_signed_mode_i;
        a_q    <= req_op_a_i;
        b_q    <= req_op_b_i;
        rd_q   <= req_rd_addr_i;
      end
      if (accept && hit) begin
        result_q <= cache_res_q;
      end else if (result_upd) begin
        result_q <= md_result_i;
      end
      if (cache_upd) begin
        cache_vld_q  <= 1'b1;
        cache_op_q   <= op_q;
        cache_mode_q <= mode_q;
        cache_a_q    <= a_q;
        cache_b_q    <= b_q;
        cache_res_q  <= md_result_i;
      end
    end
  end

  assign md_mult_en_o     = unit_active & ((op_q == MD_OP_MULL) | (op_q == MD_OP_MULH));
  assign md_div_en_o      = unit_active & ((op_q == MD_OP_DIV)  | (op_q == MD_OP_REM));
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = mode_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;
  assign md_ready_id_o    = unit_active;

  assign wb_valid_o   = (state_q == RESULT);
  assign wb_result_o  = result_q;
  assign wb_rd_addr_o = rd_q;
  assign busy_o       = (state_q != IDLE);

  assert property (@(posedge clk_i) disable iff (rst_i) !(md_mult_en_o && md_div_en_o));
  assert property (@(posedge clk_i) disable iff (rst_i) wb_valid_o |-> (state_q == RESULT));

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Directed bench for ibex_multdiv_issue; the multdiv unit is played by hand-driven md_valid_i/md_result_i.
module tb_ibex_multdiv_issue;
  import ibex_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  md_op_e      req_op_i;
  logic [1:0]  req_signed_mode_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic [4:0]  req_rd_addr_i;
  logic        kill_i;
  logic        md_mult_en_o;
  logic        md_div_en_o;
  md_op_e      md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o;
  logic [31:0] md_op_b_o;
  logic        md_ready_id_o;
  logic        md_valid_i;
  logic [31:0] md_result_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rd_addr_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  ibex_multdiv_issue #(.ResultCache(1'b1)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_op_i          (req_op_i),
    .req_signed_mode_i (req_signed_mode_i),
    .req_op_a_i        (req_op_a_i),
    .req_op_b_i        (req_op_b_i),
    .req_rd_addr_i     (req_rd_addr_i),
    .kill_i            (kill_i),
    .md_mult_en_o      (md_mult_en_o),
    .md_div_en_o       (md_div_en_o),
    .md_operator_o     (md_operator_o),
    .md_signed_mode_o  (md_signed_mode_o),
    .md_op_a_o         (md_op_a_o),
    .md_op_b_o         (md_op_b_o),
    .md_ready_id_o     (md_ready_id_o),
    .md_valid_i        (md_valid_i),
    .md_result_i       (md_result_i),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_result_o       (wb_result_o),
    .wb_rd_addr_o      (wb_rd_addr_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input md_op_e op, input logic [1:0] mode,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_valid_i       = 1'b1;
    req_op_i          = op;
    req_signed_mode_i = mode;
    req_op_a_i        = a;
    req_op_b_i        = b;
    req_rd_addr_i     = rd;
  endtask

  // Presents a request for one edge; assumes req_ready_o is high.
  task automatic issue(input md_op_e op, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    drive_req(op, mode, a, b, rd);
    step();
    req_valid_i = 1'b0;
    #1;
  endtask

  task automatic respond(input logic [31:0] res);
    md_valid_i  = 1'b1;
    md_result_i = res;
    step();
    md_valid_i  = 1'b0;
    md_result_i = 32'h0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_op_i = MD_OP_MULL;
    req_signed_mode_i = 2'b00;
    req_op_a_i = 32'h0;
    req_op_b_i = 32'h0;
    req_rd_addr_i = 5'd0;
    kill_i = 1'b0;
    md_valid_i = 1'b0;
    md_result_i = 32'h0;
    wb_ready_i = 1'b1;
    step();
    step();

    // Reset state
    chk1("rst_req_ready", req_ready_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_wb_valid", wb_valid_o, 1'b0);
    chk1("rst_mult_en", md_mult_en_o, 1'b0);
    chk1("rst_div_en", md_div_en_o, 1'b0);
    chk32("rst_op_a", md_op_a_o, 32'h0);
    chk32("rst_wb_result", wb_result_o, 32'h0);
    rst_i = 1'b0;
    #1;
    chk1("idle_req_ready", req_ready_o, 1'b1);

    // MULL 7*6
    issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd5);
    chk1("mull_busy", busy_o, 1'b1);
    chk1("mull_mult_en", md_mult_en_o, 1'b1);
    chk1("mull_div_en", md_div_en_o, 1'b0);
    chk1("mull_ready_id", md_ready_id_o, 1'b1);
    chk32("mull_op_a", md_op_a_o, 32'd7);
    chk32("mull_op_b", md_op_b_o, 32'd6);
    chk1("mull_req_ready_busy", req_ready_o, 1'b0);
    step();
    chk1("mull_mult_en_hold", md_mult_en_o, 1'b1);
    chk1("mull_wb_valid_early", wb_valid_o, 1'b0);
    respond(32'h0000002A);
    chk1("mull_wb_valid", wb_valid_o, 1'b1);
    chk32("mull_wb_result", wb_result_o, 32'h0000002A);
    chk32("mull_rd", 32'(wb_rd_addr_o), 32'd5);
    chk1("mull_mult_en_off", md_mult_en_o, 1'b0);
    step();
    chk1("mull_done_idle", busy_o, 1'b0);

    // Signed DIV then back-to-back REM on the same operands
    issue(MD_OP_DIV, 2'b11, 32'hFFFFFFF9, 32'd2, 5'd6);
    chk1("div_div_en", md_div_en_o, 1'b1);
    chk1("div_mult_en", md_mult_en_o, 1'b0);
    chk32("div_mode", 32'(md_signed_mode_o), 32'd3);
    chk32("div_operator", 32'(md_operator_o), 32'(MD_OP_DIV));
    respond(32'hFFFFFFFD);
    chk1("div_wb_valid", wb_valid_o, 1'b1);
    chk32("div_wb_result", wb_result_o, 32'hFFFFFFFD);
    drive_req(MD_OP_REM, 2'b11, 32'hFFFFFFF9, 32'd2, 5'd7);
    #1;
    chk1("rem_b2b_ready", req_ready_o, 1'b1);
    step();
    req_valid_i = 1'b0;
    #1;
    chk1("rem_miss_busy", busy_o, 1'b1);
    chk1("rem_div_en", md_div_en_o, 1'b1);
    chk1("rem_wb_valid", wb_valid_o, 1'b0);
    chk32("rem_operator", 32'(md_operator_o), 32'(MD_OP_REM));
    respond(32'hFFFFFFFF);
    chk32("rem_wb_result", wb_result_o, 32'hFFFFFFFF);
    chk32("rem_rd", 32'(wb_rd_addr_o), 32'd7);
    step();

    // MULH repeat hits the cache
    issue(MD_OP_MULH, 2'b11, 32'h80000000, 32'h80000000, 5'd8);
    respond(32'h40000000);
    chk32("mulh_wb_result", wb_result_o, 32'h40000000);
    step();
    issue(MD_OP_MULH, 2'b11, 32'h80000000, 32'h80000000, 5'd9);
    chk1("mulh_hit_wb_valid", wb_valid_o, 1'b1);
    chk32("mulh_hit_result", wb_result_o, 32'h40000000);
    chk32("mulh_hit_rd", 32'(wb_rd_addr_o), 32'd9);
    chk1("mulh_hit_mult_en", md_mult_en_o, 1'b0);
    chk1("mulh_hit_ready_id", md_ready_id_o, 1'b0);
    step();
    // Differing signed mode alone must miss
    issue(MD_OP_MULH, 2'b10, 32'h80000000, 32'h80000000, 5'd9);
    chk1("mulh_mode_miss", md_mult_en_o, 1'b1);
    chk1("mulh_mode_miss_wb", wb_valid_o, 1'b0);
    respond(32'hC0000000);
    chk32("mulh_mode_result", wb_result_o, 32'hC0000000);
    step();

    // Kill a DIV one cycle into BUSY: drain without writeback
    issue(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 5'd10);
    chk1("kill_div_en", md_div_en_o, 1'b1);
    kill_i = 1'b1;
    #1;
    chk1("kill_req_ready", req_ready_o, 1'b0);
    step();
    kill_i = 1'b0;
    #1;
    chk1("drain_div_en", md_div_en_o, 1'b1);
    chk1("drain_busy", busy_o, 1'b1);
    chk1("drain_ready_id", md_ready_id_o, 1'b1);
    chk32("drain_op_a", md_op_a_o, 32'd100);
    chk1("drain_wb_valid", wb_valid_o, 1'b0);
    step();
    chk1("drain_div_en_hold", md_div_en_o, 1'b1);
    chk32("drain_op_b", md_op_b_o, 32'd7);
    md_valid_i  = 1'b1;
    md_result_i = 32'd14;
    #1;
    chk1("drain_valid_wb", wb_valid_o, 1'b0);
    step();
    md_valid_i  = 1'b0;
    #1;
    chk1("drain_done_wb", wb_valid_o, 1'b0);
    chk1("drain_done_busy", busy_o, 1'b0);
    chk1("drain_done_ready", req_ready_o, 1'b1);
    chk1("drain_done_div_en", md_div_en_o, 1'b0);
    // The drained result still populated the cache
    issue(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 5'd10);
    chk1("drain_cache_hit_wb", wb_valid_o, 1'b1);
    chk32("drain_cache_hit_result", wb_result_o, 32'd14);
    step();

    // Writeback stall for 5 cycles, then back-to-back accept
    issue(MD_OP_MULL, 2'b00, 32'd3, 32'd5, 5'd11);
    wb_ready_i = 1'b0;
    respond(32'd15);
    drive_req(MD_OP_MULL, 2'b00, 32'd2, 32'd2, 5'd12);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("stall_wb_valid", wb_valid_o, 1'b1);
      chk32("stall_wb_result", wb_result_o, 32'd15);
      chk1("stall_req_ready", req_ready_o, 1'b0);
      step();
    end
    wb_ready_i = 1'b1;
    #1;
    chk1("release_req_ready", req_ready_o, 1'b1);
    step();
    req_valid_i = 1'b0;
    #1;
    chk1("b2b_busy", busy_o, 1'b1);
    chk1("b2b_mult_en", md_mult_en_o, 1'b1);
    chk32("b2b_op_a", md_op_a_o, 32'd2);
    chk1("b2b_wb_valid", wb_valid_o, 1'b0);
    respond(32'd4);
    chk32("b2b_wb_result", wb_result_o, 32'd4);
    chk32("b2b_rd", 32'(wb_rd_addr_o), 32'd12);
    step();

    // Reset in BUSY clears everything including the cache
    issue(MD_OP_MULL, 2'b00, 32'd9, 32'd9, 5'd13);
    respond(32'd81);
    step();
    issue(MD_OP_DIV, 2'b00, 32'd9, 32'd3, 5'd14);
    chk1("prerst_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    step();
    chk1("midrst_busy", busy_o, 1'b0);
    chk1("midrst_div_en", md_div_en_o, 1'b0);
    chk1("midrst_ready_id", md_ready_id_o, 1'b0);
    chk1("midrst_wb_valid", wb_valid_o, 1'b0);
    chk32("midrst_op_a", md_op_a_o, 32'h0);
    chk32("midrst_wb_result", wb_result_o, 32'h0);
    chk32("midrst_rd", 32'(wb_rd_addr_o), 32'd0);
    rst_i = 1'b0;
    #1;
    issue(MD_OP_MULL, 2'b00, 32'd9, 32'd9, 5'd13);
    chk1("postrst_miss_mult_en", md_mult_en_o, 1'b1);
    chk1("postrst_miss_wb", wb_valid_o, 1'b0);
    respond(32'd81);
    chk32("postrst_result", wb_result_o, 32'd81);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
